// File: rtl/t2sm_pkg.sv
// Shared definitions for the two's-complement to sign-magnitude converter.
// Holds default widths, the bit-plane count helper and a whole-word reference conversion.
// Optional statistics are enabled by defining T2SM_BLKSTAT_EN.
package t2sm_pkg;

  // Default coefficient width as it leaves the lifting DWT.
  localparam int T2SM_W = 9;

  // Widest vector the helper functions accept; callers zero-extend into it.
  localparam int T2SM_MAXW = 64;

  // Result of converting one coefficient.
  typedef struct packed {
    logic                 sign;
    logic [T2SM_MAXW-2:0] mag;
    logic                 sat;
  } t2sm_res_t;

  // Number of magnitude bit-planes: index of the highest set bit plus one,
  // zero when the magnitude is zero.
  function automatic int t2sm_planes(input logic [T2SM_MAXW-1:0] mag);
    int p;
    p = 0;
    for (int i = 0; i < T2SM_MAXW; i++) begin
      if (((mag >> i) & 64'd1) != 64'd0) begin
        p = i + 1;
      end
    end
    return p;
  endfunction

  // Convert a w-bit two's-complement word (zero-extended into data) to
  // {sign, mag, sat}; the most-negative code clips to the largest magnitude.
  function automatic t2sm_res_t t2sm_ref(input logic [T2SM_MAXW-1:0] data,
                                         input int                   w);
    t2sm_res_t            r;
    logic [T2SM_MAXW-1:0] mask;
    logic [T2SM_MAXW-1:0] a;
    logic                 neg;
    r    = '0;
    mask = (64'd1 << w) - 64'd1;
    neg  = (((data >> (w - 1)) & 64'd1) != 64'd0);
    a    = (neg ? (~data + 64'd1) : data) & mask;
    r.sat = (((a >> (w - 1)) & 64'd1) != 64'd0);
    r.sign = neg && (a != 64'd0);
    if (r.sat) begin
      r.mag = T2SM_MAXW'((64'd1 << (w - 1)) - 64'd1);
    end else begin
      r.mag = T2SM_MAXW'(a);
    end
    return r;
  endfunction

endpackage

// File: rtl/t2sm_blkstat.sv
// Per-code-block magnitude statistics: running max and bit-plane count.
// Latency: results land one cycle after the last beat's output handshake.
// Backpressure: none; observes output handshakes only, blk_valid is a bare pulse.
module t2sm_blkstat
  import t2sm_pkg::*;
#(
  parameter int W  = T2SM_W,
  parameter int PW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          beat,
  input  logic [W-2:0]  mag,
  input  logic          last,
  output logic          blk_valid,
  output logic [W-2:0]  blk_maxmag,
  output logic [PW-1:0] blk_planes
);

  logic [W-2:0] acc;
  logic [W-2:0] run_max;

  // Largest magnitude of the block so far, including the beat on the bus now.
  always_comb begin
    run_max = (mag > acc) ? mag : acc;
  end

  // Accumulate on each beat; publish and clear on the block's last beat so the
  // next block's first beat, one cycle later, starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      blk_valid  <= 1'b0;
      blk_maxmag <= '0;
      blk_planes <= '0;
    end else begin
      blk_valid <= beat && last;
      if (beat) begin
        if (last) begin
          acc        <= '0;
          blk_maxmag <= run_max;
          blk_planes <= PW'(t2sm_planes(T2SM_MAXW'(run_max)));
        end else begin
          acc <= run_max;
        end
      end
    end
  end

endmodule

// File: rtl/twoscomplement2signed.sv
// Two's-complement to sign-magnitude coefficient converter; optional block stats (T2SM_BLKSTAT_EN).
// Latency: 2 cycles from input handshake to output with out_ready high; 1 beat/cycle sustained.
// Backpressure: two-entry valid/ready pipeline; in_ready drops once both stages hold and out_ready is low.
module twoscomplement2signed
  import t2sm_pkg::*;
#(
  parameter int W  = T2SM_W,
  parameter int PW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [W-2:0]  out_mag,
  output logic          out_sat,
  output logic          out_last,
  output logic          blk_valid,
  output logic [W-2:0]  blk_maxmag,
  output logic [PW-1:0] blk_planes
);

  // Stage 1 keeps the sign and the W-bit absolute value; the raw word is not
  // needed further down because the sign bit fully describes it.
  logic         s1_valid;
  logic         s1_neg;
  logic [W-1:0] s1_abs;
  logic         s1_last;

  logic         s2_load;
  logic [W-1:0] in_abs;
  logic         cv_sign;
  logic         cv_sat;
  logic [W-2:0] cv_mag;

  // Stage 2 can take a new word when empty or when its word leaves this cycle.
  assign s2_load  = !out_valid || out_ready;
  // Stage 1 can load when empty or when its word moves into stage 2.
  assign in_ready = !s1_valid || s2_load;

  // Absolute value at full width so the most-negative code is still visible
  // as abs[W-1] set.
  always_comb begin
    in_abs = in_data[W-1] ? (~in_data + W'(1)) : in_data;
  end

  // Capture sign and absolute value on an input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_abs   <= '0;
      s1_last  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_neg  <= in_data[W-1];
        s1_abs  <= in_abs;
        s1_last <= in_last;
      end
    end
  end

  // Sign-magnitude form of the stage-1 word; only -2^(W-1) has abs[W-1] set
  // and it clips to the largest representable magnitude.
  always_comb begin
    cv_sign = s1_neg && (s1_abs != '0);
    cv_sat  = s1_abs[W-1];
    cv_mag  = cv_sat ? '1 : s1_abs[W-2:0];
  end

  // Output register; holds its word unchanged while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
      out_sat   <= 1'b0;
      out_last  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= cv_sign;
        out_mag  <= cv_mag;
        out_sat  <= cv_sat;
        out_last <= s1_last;
      end
    end
  end

`ifdef T2SM_BLKSTAT_EN
  logic out_fire;

  assign out_fire = out_valid && out_ready;

  t2sm_blkstat #(
    .W  (W),
    .PW (PW)
  ) u_blkstat (
    .clk        (clk),
    .rst        (rst),
    .beat       (out_fire),
    .mag        (out_mag),
    .last       (out_last),
    .blk_valid  (blk_valid),
    .blk_maxmag (blk_maxmag),
    .blk_planes (blk_planes)
  );
`else
  assign blk_valid  = 1'b0;
  assign blk_maxmag = '0;
  assign blk_planes = '0;
`endif

endmodule

// File: tb/tb_twoscomplement2signed.sv
// Bench for twoscomplement2signed: directed steps plus random traffic,
// checked against an arithmetic model of the conversion and block statistics.
module tb_twoscomplement2signed;
  import t2sm_pkg::*;

  localparam int W      = 9;
  localparam int PW     = $clog2(W);
  localparam int MAXMAG = (1 << (W - 1)) - 1;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data   = '0;
  logic          in_last   = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sign;
  logic [W-2:0]  out_mag;
  logic          out_sat;
  logic          out_last;
  logic          blk_valid;
  logic [W-2:0]  blk_maxmag;
  logic [PW-1:0] blk_planes;

  twoscomplement2signed #(.W(W), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_mag    (out_mag),
    .out_sat    (out_sat),
    .out_last   (out_last),
    .blk_valid  (blk_valid),
    .blk_maxmag (blk_maxmag),
    .blk_planes (blk_planes)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    bit last;
    int t;
  } beat_t;

  beat_t exp_q[$];
  int    seen_q[$];
  int    pmax_q[$];
  int    ppl_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_m = 0;
  int exp_max = 0;
  int exp_planes = 0;
  bit lat_chk  = 0;
  bit fast_chk = 0;
  bit last_acc = 0;
  bit last_rdy = 0;

  // Reference model: plain integer arithmetic on the signed value.
  function automatic int ref_abs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_mag(int v);
    return (ref_abs(v) > MAXMAG) ? MAXMAG : ref_abs(v);
  endfunction

  function automatic int ref_sat(int v);
    return (ref_abs(v) > MAXMAG) ? 1 : 0;
  endfunction

  function automatic int ref_sign(int v);
    return (v < 0) ? 1 : 0;
  endfunction

  // Bits needed to write m in binary.
  function automatic int planes_of(int m);
    int p;
    p = 0;
    while (p < 31 && (1 << p) <= m) p++;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes, update the model, step, then check stats.
  task automatic tick();
    bit           ohs;
    bit           stall;
    bit           pulse;
    logic         h_sign, h_sat, h_last;
    logic [W-2:0] h_mag;
    beat_t        b;
    int           m;
    #1;
    last_rdy = (in_ready === 1'b1);
    last_acc = (in_valid === 1'b1) && (in_ready === 1'b1) && !rst;
    ohs      = (out_valid === 1'b1) && out_ready && !rst;
    stall    = (out_valid === 1'b1) && !out_ready && !rst;
    h_sign = out_sign; h_mag = out_mag; h_sat = out_sat; h_last = out_last;
    pulse  = 0;
    if (ohs) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("out_sign", out_sign, ref_sign(b.v));
        check("out_mag",  out_mag,  ref_mag(b.v));
        check("out_sat",  out_sat,  ref_sat(b.v));
        check("out_last", out_last, b.last);
        if (lat_chk) check("latency", cyc - b.t, 2);
        seen_q.push_back(b.v);
        m = ref_mag(b.v);
        if (m > acc_m) acc_m = m;
        if (b.last) begin
          exp_max    = acc_m;
          exp_planes = planes_of(acc_m);
          acc_m      = 0;
          pulse      = 1;
        end
      end
    end
    if (last_acc) begin
      b.v    = $signed(in_data);
      b.last = in_last;
      b.t    = cyc;
      exp_q.push_back(b);
    end
    if (rst) begin
      exp_q.delete();
      acc_m = 0; exp_max = 0; exp_planes = 0; pulse = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_sign",  out_sign,  h_sign);
      check("hold_mag",   out_mag,   h_mag);
      check("hold_sat",   out_sat,   h_sat);
      check("hold_last",  out_last,  h_last);
    end
`ifdef T2SM_BLKSTAT_EN
    check("blk_valid",  blk_valid,  pulse);
    check("blk_maxmag", blk_maxmag, exp_max);
    check("blk_planes", blk_planes, exp_planes);
    if (blk_valid === 1'b1) begin
      pmax_q.push_back(int'(blk_maxmag));
      ppl_q.push_back(int'(blk_planes));
    end
`else
    check("blk_valid_tied",  blk_valid,  0);
    check("blk_maxmag_tied", blk_maxmag, 0);
    check("blk_planes_tied", blk_planes, 0);
`endif
  endtask

  task automatic send(input int v, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = W'(v); in_last = last;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 100);
    check("send_accepted", last_acc, 1);
    if (fast_chk) check("throughput", n, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("drain_done", n < 200, 1);
  endtask

  initial begin
    // Reset and reset values.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_sign",   out_sign,   0);
    check("rst_out_mag",    out_mag,    0);
    check("rst_out_sat",    out_sat,    0);
    check("rst_out_last",   out_last,   0);
    check("rst_blk_valid",  blk_valid,  0);
    check("rst_blk_maxmag", blk_maxmag, 0);
    check("rst_blk_planes", blk_planes, 0);
    check("rst_in_ready",   in_ready,   1);

    // Conversion, 2-cycle latency and full throughput.
    lat_chk = 1; fast_chk = 1;
    pmax_q.delete(); ppl_q.delete();
    send(5, 0);
    check("lat_not_yet", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_mag",   out_mag,   5);
    send(-1, 0);
    send(0, 0);
    send(255, 0);
    send(-255, 0);
    send(-256, 1);
    drain();
`ifdef T2SM_BLKSTAT_EN
    check("blk0_count", pmax_q.size(), 1);
    if (pmax_q.size() == 1) begin
      check("blk0_max",    pmax_q[0], 255);
      check("blk0_planes", ppl_q[0],  8);
    end
`endif

    // Block statistics across two blocks, the second a single beat.
    pmax_q.delete(); ppl_q.delete();
    send(3, 0);
    send(-12, 0);
    send(7, 1);
    send(1, 1);
    drain();
`ifdef T2SM_BLKSTAT_EN
    check("blk1_count", pmax_q.size(), 2);
    if (pmax_q.size() == 2) begin
      check("blk1_max",    pmax_q[0], 12);
      check("blk1_planes", ppl_q[0],  4);
      check("blk2_max",    pmax_q[1], 1);
      check("blk2_planes", ppl_q[1],  1);
    end
`endif

    // Stall: out_ready low for 5 cycles while streaming 1..10.
    lat_chk = 0; fast_chk = 0;
    seen_q.delete();
    begin : stall_blk
      int idx;
      int acc_n;
      int k;
      bit exp_rdy;
      idx = 1; acc_n = 0; k = 0;
      while (idx <= 10 && k < 200) begin
        out_ready = (k >= 5);
        in_valid  = 1'b1;
        in_data   = W'(idx);
        in_last   = (idx == 10);
        exp_rdy   = (acc_n < 2);
        tick();
        if (k < 5) check("stall_in_ready", last_rdy, exp_rdy);
        if (last_acc) begin
          idx++;
          acc_n++;
        end
        k++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("stall_all_sent", idx, 11);
    end
    drain();
    check("stall_count", seen_q.size(), 10);
    for (int i = 0; i < seen_q.size() && i < 10; i++) begin
      check("stall_order", seen_q[i], i + 1);
    end

    // All-zero block.
    pmax_q.delete(); ppl_q.delete();
    lat_chk = 1;
    for (int i = 0; i < 4; i++) send(0, i == 3);
    drain();
`ifdef T2SM_BLKSTAT_EN
    check("zero_count", pmax_q.size(), 1);
    if (pmax_q.size() == 1) begin
      check("zero_max",    pmax_q[0], 0);
      check("zero_planes", ppl_q[0],  0);
    end
`endif

    // Reset in the middle of a block, then a fresh block.
    pmax_q.delete(); ppl_q.delete();
    send(40, 0);
    send(-50, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid",  out_valid,  0);
    check("mid_rst_out_sign",   out_sign,   0);
    check("mid_rst_out_mag",    out_mag,    0);
    check("mid_rst_out_last",   out_last,   0);
    check("mid_rst_blk_valid",  blk_valid,  0);
    check("mid_rst_blk_maxmag", blk_maxmag, 0);
    check("mid_rst_in_ready",   in_ready,   1);
    send(2, 0);
    send(3, 1);
    drain();
`ifdef T2SM_BLKSTAT_EN
    check("fresh_count", pmax_q.size(), 1);
    if (pmax_q.size() == 1) begin
      check("fresh_max",    pmax_q[0], 3);
      check("fresh_planes", ppl_q[0],  2);
    end
`endif

    // Random traffic with random backpressure and idle gaps.
    lat_chk = 0;
    begin : rand_blk
      bit pend;
      pend = 0;
      for (int k = 0; k < 400; k++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!pend && $urandom_range(0, 4) != 0) begin
          pend    = 1;
          in_data = W'($urandom);
          if ($urandom_range(0, 15) == 0) in_data = {1'b1, {(W-1){1'b0}}};
          in_last = ($urandom_range(0, 4) == 0);
        end
        in_valid = pend;
        tick();
        if (last_acc) pend = 0;
      end
      in_valid = 1'b0;
    end
    drain();
    check("rand_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
